// File: rtl/oclib_csr_to_bc_pkg.sv
// Shared types and helpers for the CSR-to-byte-channel initiator bridge.
// OCLIB_CSR_TO_BC_TIMEOUT_EN adds the DRAIN state used by the response timeout.
package oclib_csr_to_bc_pkg;

   localparam int unsigned CsrAddrWidth = 32;
   localparam int unsigned CsrDataWidth = 32;

   // Request vector layout on the wire, LSB first: write, read, address, wdata.
   typedef struct packed {
      logic [CsrDataWidth-1:0] wdata;
      logic [CsrAddrWidth-1:0] address;
      logic                    read;
      logic                    write;
   } csr_bc_req_s;

   // Response vector layout on the wire, LSB first: ready, error, rdata.
   typedef struct packed {
      logic [CsrDataWidth-1:0] rdata;
      logic                    error;
      logic                    ready;
   } csr_bc_rsp_s;

   function automatic int unsigned bytes_for_bits(input int unsigned bits);
      return (bits + 7) / 8;
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_RECV,
      ST_DONE,
      ST_HOLD
`ifdef OCLIB_CSR_TO_BC_TIMEOUT_EN
      , ST_DRAIN
`endif
   } csr_bc_state_e;

endpackage

// File: rtl/oclib_csr_to_bc_if.sv
// CSR request/feedback plus both byte-channel lanes of the initiator bridge.
interface oclib_csr_to_bc_if #(
   parameter int unsigned AddressWidth = 32,
   parameter int unsigned DataWidth    = 32
);
   logic                    csrRead;
   logic                    csrWrite;
   logic [AddressWidth-1:0] csrAddress;
   logic [DataWidth-1:0]    csrWriteData;
   logic                    csrFbReady;
   logic                    csrFbError;
   logic [DataWidth-1:0]    csrFbReadData;
   logic [7:0]              bcOutData;
   logic                    bcOutValid;
   logic                    bcOutReady;
   logic [7:0]              bcInData;
   logic                    bcInValid;
   logic                    bcInReady;

   modport slave (
      input  csrRead, csrWrite, csrAddress, csrWriteData, bcOutReady, bcInData, bcInValid,
      output csrFbReady, csrFbError, csrFbReadData, bcOutData, bcOutValid, bcInReady
   );

   modport master (
      output csrRead, csrWrite, csrAddress, csrWriteData, bcOutReady, bcInData, bcInValid,
      input  csrFbReady, csrFbError, csrFbReadData, bcOutData, bcOutValid, bcInReady
   );
endinterface

// File: rtl/oclib_words_to_bc_bidi.sv
// Word-to-byte serializer followed by byte-to-word deserializer, LSB first.
// A new word is accepted only once the previous response has been collected.
module oclib_words_to_bc_bidi
   import oclib_csr_to_bc_pkg::*;
#(
   parameter int unsigned TxBits = 66,
   parameter int unsigned RxBits = 34
) (
   input  logic              clock,
   input  logic              resetN,
   input  logic [TxBits-1:0] tx_word,
   input  logic              tx_valid,
   output logic              tx_ready_c,
   output logic              tx_done_c,
   output logic [RxBits-1:0] rx_word,
   output logic              rx_valid_c,
   output logic [7:0]        bc_out_data,
   output logic              bc_out_valid,
   input  logic              bc_out_ready,
   input  logic [7:0]        bc_in_data,
   input  logic              bc_in_valid,
   output logic              bc_in_ready
);
   localparam int unsigned TxBytes = bytes_for_bits(TxBits);
   localparam int unsigned RxBytes = bytes_for_bits(RxBits);
   localparam int unsigned TxPad   = TxBytes * 8;
   localparam int unsigned TxCntW  = $clog2(TxBytes + 1);
   localparam int unsigned RxCntW  = $clog2(RxBytes + 1);

   logic [TxPad-1:0]  tx_shift_q, tx_shift_d;
   logic [TxCntW-1:0] tx_cnt_q, tx_cnt_d;
   logic [RxCntW-1:0] rx_cnt_q, rx_cnt_d;
   logic [RxBits-1:0] rx_word_q, rx_word_d;
   logic              tx_busy_q, tx_busy_d;
   logic              rx_busy_q, rx_busy_d;
   logic              tx_fire_c, rx_fire_c;

   assign tx_fire_c = tx_busy_q & bc_out_ready;
   assign rx_fire_c = rx_busy_q & bc_in_valid;

   always_comb begin
      tx_shift_d = tx_shift_q;
      tx_cnt_d   = tx_cnt_q;
      tx_busy_d  = tx_busy_q;
      rx_cnt_d   = rx_cnt_q;
      rx_word_d  = rx_word_q;
      rx_busy_d  = rx_busy_q;
      tx_ready_c = !tx_busy_q && !rx_busy_q;
      tx_done_c  = tx_fire_c && (tx_cnt_q == TxCntW'(TxBytes - 1));
      rx_valid_c = rx_fire_c && (rx_cnt_q == RxCntW'(RxBytes - 1));

      if (tx_valid && tx_ready_c) begin
         tx_shift_d = TxPad'(tx_word);
         tx_cnt_d   = '0;
         tx_busy_d  = 1'b1;
      end

      if (tx_fire_c) begin
         tx_shift_d = {8'h00, tx_shift_q[TxPad-1:8]};
         tx_cnt_d   = tx_cnt_q + TxCntW'(1);
         if (tx_done_c) begin
            tx_busy_d = 1'b0;
            rx_busy_d = 1'b1;
            rx_cnt_d  = '0;
         end
      end

      // Drop each incoming byte into its lane; bits past RxBits are padding.
      if (rx_fire_c) begin
         for (int b = 0; b < int'(RxBits); b++) begin
            if (RxCntW'(b / 8) == rx_cnt_q) rx_word_d[b] = bc_in_data[b % 8];
         end
         rx_cnt_d = rx_cnt_q + RxCntW'(1);
         if (rx_valid_c) rx_busy_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         tx_shift_q <= '0;
         tx_cnt_q   <= '0;
         tx_busy_q  <= 1'b0;
         rx_cnt_q   <= '0;
         rx_word_q  <= '0;
         rx_busy_q  <= 1'b0;
      end else begin
         tx_shift_q <= tx_shift_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_busy_q  <= tx_busy_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_word_q  <= rx_word_d;
         rx_busy_q  <= rx_busy_d;
      end
   end

   assign bc_out_data  = tx_shift_q[7:0];
   assign bc_out_valid = tx_busy_q;
   assign bc_in_ready  = rx_busy_q;
   assign rx_word      = rx_word_q;

endmodule

// File: rtl/oclib_csr_to_bc.sv
// CSR slave to bidirectional byte-channel bridge (initiator side).
// Define OCLIB_CSR_TO_BC_TIMEOUT_EN to bound the wait for a response.
module oclib_csr_to_bc
   import oclib_csr_to_bc_pkg::*;
#(
   parameter int unsigned AddressWidth = 32,
   parameter int unsigned DataWidth    = 32
`ifdef OCLIB_CSR_TO_BC_TIMEOUT_EN
   , parameter int unsigned TimeoutCycles = 4096
`endif
) (
   input  logic               clock,
   input  logic               resetN,
   oclib_csr_to_bc_if.slave   bus
);
   localparam int unsigned ReqBits = 2 + AddressWidth + DataWidth;
   localparam int unsigned RspBits = 2 + DataWidth;

   csr_bc_state_e        state_q, state_d;
   logic                 fb_ready_q, fb_ready_d;
   logic                 fb_error_q, fb_error_d;
   logic [DataWidth-1:0] fb_rdata_q, fb_rdata_d;
   logic [RspBits-1:0]   rsp_word;
   logic                 any_req_c, one_req_c, both_req_c;
   logic                 tx_valid_c, tx_ready_c, tx_done_c, rx_valid_c;

   assign any_req_c  = bus.csrRead | bus.csrWrite;
   assign one_req_c  = bus.csrRead ^ bus.csrWrite;
   assign both_req_c = bus.csrRead & bus.csrWrite;
   assign tx_valid_c = (state_q == ST_IDLE) && one_req_c;

   oclib_words_to_bc_bidi #(
      .TxBits (ReqBits),
      .RxBits (RspBits)
   ) u_bidi (
      .clock        (clock),
      .resetN       (resetN),
      .tx_word      ({bus.csrWriteData, bus.csrAddress, bus.csrRead, bus.csrWrite}),
      .tx_valid     (tx_valid_c),
      .tx_ready_c   (tx_ready_c),
      .tx_done_c    (tx_done_c),
      .rx_word      (rsp_word),
      .rx_valid_c   (rx_valid_c),
      .bc_out_data  (bus.bcOutData),
      .bc_out_valid (bus.bcOutValid),
      .bc_out_ready (bus.bcOutReady),
      .bc_in_data   (bus.bcInData),
      .bc_in_valid  (bus.bcInValid),
      .bc_in_ready  (bus.bcInReady)
   );

`ifdef OCLIB_CSR_TO_BC_TIMEOUT_EN
   // Idle-cycle counter in RECV; any received byte restarts it.
   localparam int unsigned TimerW = $clog2(TimeoutCycles + 1);
   logic [TimerW-1:0] timer_q, timer_d;
   logic              rx_byte_c, timeout_c;

   assign rx_byte_c = bus.bcInValid & bus.bcInReady;
   assign timeout_c = (state_q == ST_RECV) && !rx_byte_c &&
                      (timer_q == TimerW'(TimeoutCycles - 1));

   always_comb begin
      timer_d = '0;
      if ((state_q == ST_RECV) && !rx_byte_c) timer_d = timer_q + TimerW'(1);
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) timer_q <= '0;
      else         timer_q <= timer_d;
   end
`endif

   always_comb begin
      state_d    = state_q;
      fb_ready_d = 1'b0;
      fb_error_d = 1'b0;
      fb_rdata_d = '0;
      case (state_q)
         ST_IDLE: begin
            if (both_req_c) begin
               fb_ready_d = 1'b1;
               fb_error_d = 1'b1;
               state_d    = ST_HOLD;
            end else if (one_req_c && tx_ready_c) begin
               state_d = ST_SEND;
            end
         end
         ST_SEND: if (tx_done_c) state_d = ST_RECV;
         ST_RECV: begin
            if (rx_valid_c) state_d = ST_DONE;
`ifdef OCLIB_CSR_TO_BC_TIMEOUT_EN
            else if (timeout_c) begin
               fb_ready_d = 1'b1;
               fb_error_d = 1'b1;
               state_d    = ST_DRAIN;
            end
`endif
         end
         // A response without its ready bit is a protocol error.
         ST_DONE: begin
            fb_ready_d = 1'b1;
            fb_error_d = rsp_word[1] | ~rsp_word[0];
            fb_rdata_d = rsp_word[RspBits-1:2];
            state_d    = ST_HOLD;
         end
         ST_HOLD: if (!any_req_c) state_d = ST_IDLE;
`ifdef OCLIB_CSR_TO_BC_TIMEOUT_EN
         ST_DRAIN: if (rx_valid_c) state_d = any_req_c ? ST_HOLD : ST_IDLE;
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q    <= ST_IDLE;
         fb_ready_q <= 1'b0;
         fb_error_q <= 1'b0;
         fb_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         fb_ready_q <= fb_ready_d;
         fb_error_q <= fb_error_d;
         fb_rdata_q <= fb_rdata_d;
      end
   end

   assign bus.csrFbReady    = fb_ready_q;
   assign bus.csrFbError    = fb_error_q;
   assign bus.csrFbReadData = fb_rdata_q;

endmodule

// File: tb/tb_oclib_csr_to_bc.sv
// Scoreboard bench for oclib_csr_to_bc: directed and stalled random CSR traffic.
module tb_oclib_csr_to_bc;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } fb_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   oclib_csr_to_bc_if bus ();

   oclib_csr_to_bc dut (
      .clock  (clk),
      .resetN (rst_n),
      .bus    (bus)
   );

   int         total = 0;
   int         bad   = 0;
   int         fb_seen = 0;
   int         req_issued = 0;
   bit         stall_en = 1'b0;
   bit         in_fire;
   logic [7:0] exp_req_q[$];
   logic [7:0] rsp_q[$];
   fb_t        exp_fb_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      total++;
      bad++;
      $display("FAIL %s", name);
   endtask

   // Monitor: every accepted request byte and every feedback pulse is scored.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.bcOutValid && bus.bcOutReady) begin
            if (exp_req_q.size() == 0) flag("req_byte_unexpected");
            else check("req_byte", 64'(bus.bcOutData), 64'(exp_req_q.pop_front()));
         end
         if (bus.csrFbReady) begin
            fb_t e;
            fb_seen++;
            if (exp_fb_q.size() == 0) flag("fb_unexpected");
            else begin
               e = exp_fb_q.pop_front();
               check("fb_error", 64'(bus.csrFbError), 64'(e.err));
               check("fb_rdata", 64'(bus.csrFbReadData), 64'(e.rdata));
            end
         end
      end
   end

   // Far end: accepts request bytes and plays back queued response bytes.
   initial begin
      bus.bcOutReady = 1'b0;
      bus.bcInValid  = 1'b0;
      bus.bcInData   = 8'h00;
      forever begin
         @(negedge clk);
         in_fire = bus.bcInValid && bus.bcInReady;
         @(posedge clk);
         #1;
         if (in_fire && rsp_q.size() > 0) void'(rsp_q.pop_front());
         bus.bcInValid  = (rsp_q.size() > 0) && (!stall_en || $urandom_range(0, 1) == 1);
         bus.bcInData   = (rsp_q.size() > 0) ? rsp_q[0] : 8'h00;
         bus.bcOutReady = !stall_en || $urandom_range(0, 1) == 1;
      end
   end

   task automatic push_req(input logic [71:0] v);
      for (int i = 0; i < 9; i++) exp_req_q.push_back(v[8*i +: 8]);
   endtask

   task automatic push_rsp(input logic [39:0] v);
      for (int i = 0; i < 5; i++) rsp_q.push_back(v[8*i +: 8]);
   endtask

   task automatic push_fb(input logic err, input logic [31:0] rdata);
      fb_t e;
      e.err   = err;
      e.rdata = rdata;
      exp_fb_q.push_back(e);
   endtask

   task automatic csr_txn(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int exp_lat);
      int lat;
      @(posedge clk);
      #1;
      bus.csrRead      = rd;
      bus.csrWrite     = wr;
      bus.csrAddress   = addr;
      bus.csrWriteData = wdata;
      req_issued++;
      lat = 0;
      for (int i = 1; i <= 3000; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.csrFbReady) begin
            lat = i;
            break;
         end
      end
      if (lat == 0) flag("fb_wait_expired");
      else if (exp_lat > 0) check("latency", 64'(lat), 64'(exp_lat));
      @(posedge clk);
      #1;
      bus.csrRead  = 1'b0;
      bus.csrWrite = 1'b0;
   endtask

   initial begin
      bus.csrRead      = 1'b0;
      bus.csrWrite     = 1'b0;
      bus.csrAddress   = '0;
      bus.csrWriteData = '0;
      rst_n = 1'b1;
      #3 rst_n = 1'b0;
      #20;
      check("rst_fb_ready", 64'(bus.csrFbReady), 64'd0);
      check("rst_fb_error", 64'(bus.csrFbError), 64'd0);
      check("rst_fb_rdata", 64'(bus.csrFbReadData), 64'd0);
      check("rst_out_valid", 64'(bus.bcOutValid), 64'd0);
      check("rst_out_data", 64'(bus.bcOutData), 64'd0);
      check("rst_in_ready", 64'(bus.bcInReady), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Write 0x10 <= 0xDEADBEEF, clean response, no stalls.
      push_req(72'h03_7A_B6_FB_BC_00_00_00_41);
      push_rsp(40'h00_00_00_00_01);
      push_fb(1'b0, 32'h0);
      csr_txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 16);

      // Read 0x4, rdata assembled across byte boundaries.
      push_req(72'h00_00_00_00_00_00_00_00_12);
      push_rsp(40'h02_1F_D5_9C_01);
      push_fb(1'b0, 32'h87F5_6700);
      csr_txn(1'b1, 1'b0, 32'h0000_0004, 32'h0, 16);

      // Read and write together: no byte traffic, error after one cycle.
      push_fb(1'b1, 32'h0);
      csr_txn(1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1);

      // Response without its ready bit.
      push_req(72'h00_00_00_00_04_00_00_00_21);
      push_rsp(40'h00_00_00_00_00);
      push_fb(1'b1, 32'h0);
      csr_txn(1'b0, 1'b1, 32'h0000_0008, 32'h0000_0001, 16);

      // Remote reports an error with data.
      push_req(72'h00_00_00_00_00_00_00_00_02);
      push_rsp(40'h00_00_00_04_03);
      push_fb(1'b1, 32'h0000_0100);
      csr_txn(1'b1, 1'b0, 32'h0, 32'h0, 16);

      // Random traffic with stalls on both lanes.
      stall_en = 1'b1;
      for (int t = 0; t < 200; t++) begin
         bit          rd, rdy, er;
         logic [31:0] a, d, rdat;
         rd   = 1'($urandom_range(0, 1));
         a    = $urandom();
         d    = $urandom();
         rdat = $urandom();
         rdy  = ($urandom_range(0, 3) != 0);
         er   = ($urandom_range(0, 3) == 0);
         push_req(72'({d, a, rd, !rd}));
         push_rsp(40'({rdat, er, rdy}));
         push_fb(er | !rdy, rdat);
         csr_txn(rd, !rd, a, d, 0);
      end
      stall_en = 1'b0;
      repeat (4) @(posedge clk);

      // Reset in the middle of SEND abandons the write silently.
      push_req(72'h03_7A_B6_FB_BC_00_00_00_41);
      @(posedge clk);
      #1;
      bus.csrWrite     = 1'b1;
      bus.csrAddress   = 32'h10;
      bus.csrWriteData = 32'hDEAD_BEEF;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         if (exp_req_q.size() <= 6) break;
      end
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 64'(bus.bcOutValid), 64'd0);
      check("mid_rst_out_data", 64'(bus.bcOutData), 64'd0);
      check("mid_rst_in_ready", 64'(bus.bcInReady), 64'd0);
      check("mid_rst_fb_ready", 64'(bus.csrFbReady), 64'd0);
      check("mid_rst_bytes_sent", 64'(exp_req_q.size() < 9 && exp_req_q.size() > 0), 64'd1);
      exp_req_q.delete();
      rsp_q.delete();
      bus.csrWrite = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      push_req(72'h03_7A_B6_FB_BC_00_00_00_41);
      push_rsp(40'h00_00_00_00_01);
      push_fb(1'b0, 32'h0);
      csr_txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 16);

      repeat (5) @(posedge clk);
      check("fb_count", 64'(fb_seen), 64'(req_issued));
      check("req_q_drained", 64'(exp_req_q.size()), 64'd0);
      check("fb_q_drained", 64'(exp_fb_q.size()), 64'd0);
      check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
